// File: rtl/switch4_pkg.sv
// Shared constants and helpers for the four-switch input reader.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package switch4_pkg;

    localparam int NUM_SW           = 4;
    localparam int DEF_TICK_BITS    = 22;
    localparam int DEF_STABLE_TICKS = 4;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/switch4_reader_debounce_bit.sv
// One switch bit: 2-flop synchroniser followed by a tick-paced debounce counter.
// Latency: 2 cycles to sync, then STABLE_TICKS ticks of agreement before dout moves.
// Backpressure: none; the bit is sampled every cycle and never stalls.
module debounce_bit
    import switch4_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_din,
    input  logic i_tick,
    output logic o_dout
);

    localparam int CW = cnt_width(STABLE_TICKS);

    logic          r_meta;
    logic          r_sync;
    logic          r_dout;
    logic [CW-1:0] r_cnt;

    // Synchronise the pin; count ticks while the synced value disagrees with dout.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            if (r_sync == r_dout) begin
                // Agreement (including a bounce back) throws away any partial count.
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == CW'(STABLE_TICKS - 1)) begin
                    r_dout <= r_sync;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/switch4_reader.sv
// Four debounced switch inputs with edge pulses and a latched change-event handshake.
// Latency: din->dout 2+STABLE_TICKS*2**TICK_BITS worst case, +1 to rise/fall, +1 to chg_valid.
// Backpressure: events accumulate into chg_mask until chg_ack; re-change of a pending bit sets chg_ovf.
// Optional: define SWITCH4_PRESS_CNT_EN to add press_cnt (four wrapping 8-bit rise counters).
module switch4_reader
    import switch4_pkg::*;
#(
    parameter int TICK_BITS    = DEF_TICK_BITS,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_SW-1:0] din,
    output logic [NUM_SW-1:0] dout,
    output logic [NUM_SW-1:0] rise,
    output logic [NUM_SW-1:0] fall,
    output logic              chg_valid,
    output logic [NUM_SW-1:0] chg_mask,
    output logic              chg_ovf,
    input  logic              chg_ack
`ifdef SWITCH4_PRESS_CNT_EN
    ,
    output logic [8*NUM_SW-1:0] press_cnt
`endif
);

    logic [TICK_BITS-1:0] r_tick_cnt;
    logic                 w_tick;
    logic [NUM_SW-1:0]    w_dout;
    logic [NUM_SW-1:0]    r_dout_d;
    logic [NUM_SW-1:0]    r_rise;
    logic [NUM_SW-1:0]    r_fall;
    logic [NUM_SW-1:0]    w_new;
    logic                 r_chg_valid;
    logic [NUM_SW-1:0]    r_chg_mask;
    logic                 r_chg_ovf;

    // Free-running tick counter; the tick is a one-cycle enable at all-ones.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
        end
    end

    assign w_tick = &r_tick_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_debounce_bit (
                .clk_in (clk_in),
                .rst_in (rst_in),
                .i_din  (din[gi]),
                .i_tick (w_tick),
                .o_dout (w_dout[gi])
            );
        end
    endgenerate

    // Edge detect on the debounced value, registered so pulses follow dout by one cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dout_d <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_dout_d <= w_dout;
            r_rise   <= w_dout & ~r_dout_d;
            r_fall   <= ~w_dout & r_dout_d;
        end
    end

    assign w_new = r_rise | r_fall;

    // Change-event handshake: accumulate changed bits until acked; a change in the ack cycle opens a new event.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_chg_valid <= 1'b0;
            r_chg_mask  <= '0;
            r_chg_ovf   <= 1'b0;
        end else if (r_chg_valid && chg_ack) begin
            r_chg_mask  <= w_new;
            r_chg_valid <= |w_new;
            r_chg_ovf   <= 1'b0;
        end else if (r_chg_valid) begin
            r_chg_mask <= r_chg_mask | w_new;
            if (|(r_chg_mask & w_new)) begin
                r_chg_ovf <= 1'b1;
            end
        end else if (|w_new) begin
            r_chg_mask  <= w_new;
            r_chg_valid <= 1'b1;
        end
    end

    assign dout      = w_dout;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign chg_valid = r_chg_valid;
    assign chg_mask  = r_chg_mask;
    assign chg_ovf   = r_chg_ovf;

`ifdef SWITCH4_PRESS_CNT_EN
    logic [7:0] r_press [NUM_SW];

    // Per-bit press counters, advancing on each rise pulse and wrapping at 255.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_SW; i++) begin
                r_press[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (r_rise[i]) begin
                    r_press[i] <= r_press[i] + 8'd1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_press
            assign press_cnt[8*gi +: 8] = r_press[gi];
        end
    endgenerate
`endif

endmodule

// File: doc/switch4_reader.md
Name: switch4_reader

Overview:
- Input-side counterpart of the LED register path: samples four asynchronous switch/button pins and presents clean, debounced 4-bit data to the fabric.
- Per-bit flow: 2-flop synchroniser, then a tick-paced debounce counter, then edge pulses and a latched change-event handshake.
- Sits between the board pins and any logic that consumes user input. Single clock domain; the internal tick is a clock-enable, not a derived clock.

Parameters:
- TICK_BITS, 22: width of the free-running tick counter; tick period = 2**TICK_BITS cycles.
- STABLE_TICKS, 4: consecutive ticks a synchronised input must differ from the debounced value before it is accepted; legal range 1..255.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset, synchronous, active-high.
- din, input, 4: raw asynchronous switch pins.
- dout, output, 4: debounced stable value.
- rise, output, 4: one-cycle pulse per bit on a dout 0->1 change.
- fall, output, 4: one-cycle pulse per bit on a dout 1->0 change.
- chg_valid, output, 1: change event pending.
- chg_mask, output, 4: bits changed since the last ack.
- chg_ovf, output, 1: a bit changed again while its mask bit was already pending.
- chg_ack, input, 1: consumer accepts the event.

Behaviour:
- Reset (rst_in=1 at a clk_in edge) clears all state: sync flops, tick counter, debounce counters, dout, rise, fall, chg_valid, chg_mask, chg_ovf (and press counters if enabled) are all 0. Reset mid-debounce discards partial counts.
- Synchroniser: two flops per bit; sync = 2nd stage. Two cycles of latency.
- Tick counter: increments every cycle and wraps. tick=1 for exactly one cycle when the count is all-ones. The first tick occurs 2**TICK_BITS-1 cycles after reset release.
- Debounce, per bit, counter width $clog2(STABLE_TICKS+1):
  - sync==dout: the counter clears on any cycle.
  - sync!=dout and tick: if counter==STABLE_TICKS-1, then dout<=sync and the counter clears; otherwise the counter increments.
  - Any bounce back to dout restarts the count.
- rise[i]/fall[i]: registered and asserted in the cycle after dout[i] changes; each lasts one cycle.
- Event handshake: let new = rise|fall (bits changing this cycle).
  - Idle (chg_valid=0): a nonzero new sets chg_mask<=new and chg_valid<=1.
  - Pending without ack: chg_mask<=chg_mask|new. chg_ovf<=1 if (chg_mask & new)!=0. chg_ovf is sticky.
  - chg_ack & chg_valid: chg_mask<=new, chg_valid<=(new!=0), chg_ovf<=0. A change in the ack cycle is never lost.
  - chg_ack while chg_valid=0 is ignored.
- chg_valid, chg_mask and chg_ovf are all registered outputs.
- Worst-case latency from a stable din change to dout: 2 + STABLE_TICKS*2**TICK_BITS cycles, +1 cycle to rise/fall, +1 cycle to chg_valid.

Optional Feature:
- Macro: SWITCH4_PRESS_CNT_EN.
- Defined: adds output press_cnt[31:0], four 8-bit counters; byte i counts rise[i] events. Counters wrap 255->0 and reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package switch4_pkg holds:
  - NUM_SW=4;
  - the default TICK_BITS and STABLE_TICKS;
  - function cnt_width(n) returning $clog2(n+1).
- One sub-module, debounce_bit, is instantiated 4x. It contains the synchroniser, debounce counter and dout bit, and takes tick as an input.
- The tick counter, edge logic, handshake and optional counters live in the top module.

Test Plan:
All scenarios use TICK_BITS=2 (tick every 4 cycles) and STABLE_TICKS=3.
- Clean press: din=0001 held from reset release -> dout=0001 within 2+12 cycles; rise=0001 for one cycle; chg_valid=1, chg_mask=0001; fall stays 0.
- Bounce: din[0] toggled every 5 cycles for 40 cycles, then held 0 -> dout stays 0000, no rise, chg_valid stays 0.
- Accumulation and overflow: din=0001 accepted; then din=0011 accepted; then din=0010 accepted, all with ack held 0 -> chg_mask=0011, chg_ovf=1. Assert chg_ack for one cycle -> chg_valid=0, chg_mask=0000, chg_ovf=0.
- Ack collision: chg_ack asserted in the same cycle rise=0100 pulses -> next cycle chg_valid=1, chg_mask=0100, chg_ovf=0.
- Reset mid-operation: din=1111 held for 8 cycles, then rst_in pulsed for 1 cycle with din still 1111 -> all outputs 0; dout=1111 only after a full 2+12 cycles from reset release.
- SWITCH4_PRESS_CNT_EN: 256 accepted presses on bit 3 -> press_cnt[31:24] reads 0 (wrap); one more press gives 1; the other bytes stay 0.
